// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch sequencer: widths, FSM states
// and the fetch-queue entry layout.
package fetch_pkg;

   localparam int unsigned PC_W    = 16;
   localparam int unsigned INSTR_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HALTED
   } fetch_state_e;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/insfetch_ctrl_if.sv
// Fetch bus: ROM address/data, decode valid/ready handshake, redirect and halt.
// master = fetch sequencer, slave = surrounding core (ROM, decode, branch unit).
interface insfetch_ctrl_if;

   logic [fetch_pkg::PC_W-1:0]    mem_pc;
   logic [fetch_pkg::INSTR_W-1:0] mem_instr;
   logic                          out_valid;
   logic                          out_ready;
   logic [fetch_pkg::INSTR_W-1:0] out_instr;
   logic [fetch_pkg::PC_W-1:0]    out_pc;
   logic                          redirect_valid;
   logic [fetch_pkg::PC_W-1:0]    redirect_pc;
   logic                          halt_req;
   logic                          halted;

   modport master (
      output mem_pc, out_valid, out_instr, out_pc, halted,
      input  mem_instr, out_ready, redirect_valid, redirect_pc, halt_req
   );

   modport slave (
      input  mem_pc, out_valid, out_instr, out_pc, halted,
      output mem_instr, out_ready, redirect_valid, redirect_pc, halt_req
   );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {pc, instr} entries; flush overrides push/pop.
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t din,
   output logic         full,
   output logic         empty,
   output fetch_entry_t head
);

   localparam int unsigned AW = $clog2(DEPTH);

   fetch_entry_t   mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [AW:0]    count;
   logic           do_push;
   logic           do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_pop  = pop && !empty;
   // a push into a full queue is legal when the head leaves in the same cycle
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (do_push && !do_pop) begin
            count <= count + (AW+1)'(1);
         end else if (!do_push && do_pop) begin
            count <= count - (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/insfetch_ctrl.sv
// Instruction-fetch sequencer: owns the pc, fetches from a combinational ROM into
// a small queue, handles redirect/halt. Optional counters: `INSFETCH_PERF_EN.
module insfetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
   parameter int unsigned     PC_STEP  = 2,
   parameter int unsigned     QDEPTH   = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   insfetch_ctrl_if.master      bus
`ifdef INSFETCH_PERF_EN
   ,
   output logic [31:0]          perf_fetched,
   output logic [31:0]          perf_stall
`endif
);

   fetch_state_e    state_q;
   fetch_state_e    state_d;
   logic [PC_W-1:0] pc_q;
   logic            run;
   logic            redir;
   logic            pop;
   logic            capture;
   logic            q_full;
   logic            q_empty;
   fetch_entry_t    head;
   fetch_entry_t    push_entry;

   // redirect is ignored in IDLE; when taken it also kills any same-cycle capture
   assign redir      = bus.redirect_valid && (state_q != IDLE);
   assign pop        = !q_empty && bus.out_ready;
   assign capture    = run && !redir && (!q_full || pop);
   assign push_entry = '{pc: pc_q, instr: bus.mem_instr};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    state_d = RUN;
         RUN:     if (redir)             state_d = RUN;
                  else if (bus.halt_req) state_d = HALTED;
         HALTED:  if (redir)             state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      run        = (state_q == RUN);
      bus.halted = (state_q == HALTED);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else if (redir) begin
         pc_q <= bus.redirect_pc & ~PC_W'(1);
      end else if (capture) begin
         pc_q <= pc_q + PC_W'(PC_STEP);
      end
   end

   fetch_queue #(
      .DEPTH (QDEPTH)
   ) u_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (capture),
      .pop   (pop),
      .flush (redir),
      .din   (push_entry),
      .full  (q_full),
      .empty (q_empty),
      .head  (head)
   );

   assign bus.mem_pc    = pc_q;
   assign bus.out_valid = !q_empty;
   assign bus.out_pc    = head.pc;
   assign bus.out_instr = head.instr;

`ifdef INSFETCH_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
      end else begin
         if (capture) begin
            perf_fetched <= perf_fetched + 32'd1;
         end
         if (run && q_full && !pop) begin
            perf_stall <= perf_stall + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_insfetch_ctrl.sv
// Bench for insfetch_ctrl: ROM model, scoreboard of expected {pc, instr} in
// program order, popped and compared on every decode handshake.
module tb_insfetch_ctrl;
   import fetch_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   vectors     = 0;
   int   miscompares = 0;

   fetch_entry_t sb[$];

   insfetch_ctrl_if bus();

`ifdef INSFETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_stall;
`endif

   insfetch_ctrl #(
      .RESET_PC (16'h0000),
      .PC_STEP  (2),
      .QDEPTH   (2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus)
`ifdef INSFETCH_PERF_EN
      ,
      .perf_fetched (perf_fetched),
      .perf_stall   (perf_stall)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] rom_word(input logic [15:0] a);
      logic [3:0] idx;
      idx = a[4:1];
      return 16'hA001 + {12'h000, idx};
   endfunction

   assign bus.mem_instr = rom_word(bus.mem_pc);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_load(input logic [15:0] start, input int n);
      fetch_entry_t e;
      sb.delete();
      for (int i = 0; i < n; i++) begin
         e.pc    = start + 16'(2 * i);
         e.instr = rom_word(e.pc);
         sb.push_back(e);
      end
   endtask

   // a pop coinciding with a redirect never reaches decode
   always @(negedge clk) begin
      fetch_entry_t e;
      if (rst_n && bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
         chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("pop_pc", 32'(bus.out_pc), 32'(e.pc));
            chk("pop_instr", 32'(bus.out_instr), 32'(e.instr));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      rst_n              = 1'b0;
      bus.out_ready      = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 16'h0000;
      bus.halt_req       = 1'b0;
      cyc();
      cyc();
      chk("rst_valid",  32'(bus.out_valid), 32'd0);
      chk("rst_mem_pc", 32'(bus.mem_pc),    32'h0000);
      chk("rst_out_pc", 32'(bus.out_pc),    32'h0000);
      chk("rst_instr",  32'(bus.out_instr), 32'h0000);
      chk("rst_halted", 32'(bus.halted),    32'd0);

      // startup latency and streaming
      rst_n = 1'b1;
      sb_load(16'h0000, 8);
      cyc();
      chk("idle_mem_pc", 32'(bus.mem_pc),    32'h0000);
      chk("idle_valid",  32'(bus.out_valid), 32'd0);
      cyc();
      chk("run1_mem_pc", 32'(bus.mem_pc),    32'h0002);
      chk("run1_valid",  32'(bus.out_valid), 32'd1);
      chk("run1_pc",     32'(bus.out_pc),    32'h0000);
      chk("run1_instr",  32'(bus.out_instr), 32'hA001);
      cyc();
      chk("run2_mem_pc", 32'(bus.mem_pc),    32'h0004);
      chk("run2_pc",     32'(bus.out_pc),    32'h0002);
      chk("run2_instr",  32'(bus.out_instr), 32'hA002);

      // backpressure from reset
      rst_n = 1'b0;
      bus.out_ready = 1'b0;
      sb.delete();
      cyc();
      rst_n = 1'b1;
      sb_load(16'h0000, 8);
      repeat (5) cyc();
      chk("stall_mem_pc", 32'(bus.mem_pc),    32'h0004);
      chk("stall_valid",  32'(bus.out_valid), 32'd1);
      chk("stall_pc",     32'(bus.out_pc),    32'h0000);
      chk("stall_instr",  32'(bus.out_instr), 32'hA001);
      bus.out_ready = 1'b1;
      repeat (3) cyc();
      chk("release_pc", 32'(bus.out_pc), 32'h0006);

      // redirect with a full queue, odd target
      bus.out_ready      = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 16'h0013;
      sb_load(16'h0012, 8);
      cyc();
      chk("redir_valid",  32'(bus.out_valid), 32'd0);
      chk("redir_mem_pc", 32'(bus.mem_pc),    32'h0012);
      bus.redirect_valid = 1'b0;
      bus.out_ready      = 1'b1;
      cyc();
      chk("redir_first_valid", 32'(bus.out_valid), 32'd1);
      chk("redir_first_pc",    32'(bus.out_pc),    32'h0012);
      chk("redir_first_instr", 32'(bus.out_instr), 32'hA00A);

      // halt with a full queue, drain, resume by redirect
      bus.out_ready = 1'b0;
      cyc();
      cyc();
      chk("full_hold_mem_pc", 32'(bus.mem_pc), 32'h0016);
      bus.halt_req = 1'b1;
      cyc();
      chk("halt_set", 32'(bus.halted), 32'd1);
      bus.halt_req  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (4) cyc();
      chk("halt_drained",  32'(bus.out_valid), 32'd0);
      chk("halt_no_fetch", 32'(bus.mem_pc),    32'h0016);
      chk("halt_kept",     32'(bus.halted),    32'd1);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 16'h0000;
      sb_load(16'h0000, 8);
      cyc();
      chk("resume_halted", 32'(bus.halted),    32'd0);
      chk("resume_mem_pc", 32'(bus.mem_pc),    32'h0000);
      chk("resume_valid",  32'(bus.out_valid), 32'd0);
      bus.redirect_valid = 1'b0;
      cyc();
      chk("resume_first_valid", 32'(bus.out_valid), 32'd1);
      chk("resume_first_pc",    32'(bus.out_pc),    32'h0000);

      // redirect and halt together: redirect wins
      bus.redirect_valid = 1'b1;
      bus.halt_req       = 1'b1;
      bus.redirect_pc    = 16'h0100;
      sb_load(16'h0100, 8);
      cyc();
      chk("both_halted", 32'(bus.halted), 32'd0);
      chk("both_mem_pc", 32'(bus.mem_pc), 32'h0100);
      bus.redirect_valid = 1'b0;
      bus.halt_req       = 1'b0;
      cyc();
      cyc();
      chk("both_run_halted", 32'(bus.halted), 32'd0);
      chk("both_run_mem_pc", 32'(bus.mem_pc), 32'h0104);

      // halt request in a capture cycle still captures
      bus.halt_req = 1'b1;
      cyc();
      chk("halt_cap_mem_pc", 32'(bus.mem_pc), 32'h0106);
      chk("halt_cap_halted", 32'(bus.halted), 32'd1);
      bus.halt_req = 1'b0;
      repeat (3) cyc();
      chk("halt_cap_drained", 32'(bus.out_valid), 32'd0);

      // pc wrap at the top of the address space
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 16'hFFFE;
      sb_load(16'hFFFE, 3);
      cyc();
      bus.redirect_valid = 1'b0;
      repeat (4) cyc();
      bus.out_ready = 1'b0;
      chk("wrap_sb_done", 32'(sb.size()),    32'd0);
      chk("wrap_valid",   32'(bus.out_valid), 32'd1);
      chk("wrap_head_pc", 32'(bus.out_pc),    32'h0004);

      // asynchronous reset mid-operation
      #2;
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk("arst_valid",  32'(bus.out_valid), 32'd0);
      chk("arst_mem_pc", 32'(bus.mem_pc),    32'h0000);
      chk("arst_out_pc", 32'(bus.out_pc),    32'h0000);
      chk("arst_halted", 32'(bus.halted),    32'd0);

`ifdef INSFETCH_PERF_EN
      cyc();
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      sb_load(16'h0000, 8);
      repeat (6) cyc();
      chk("perf_fetched_run", perf_fetched, 32'd5);
      chk("perf_stall_run",   perf_stall,   32'd0);
      bus.out_ready = 1'b0;
      repeat (4) cyc();
      chk("perf_fetched_stall", perf_fetched, 32'd6);
      chk("perf_stall_stall",   perf_stall,   32'd3);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
